// File: rtl/btb_pkg.sv
// btb_pkg: shared constants and helpers for the branch target buffer.
//   - 2-bit direction counter encodings and saturating update
//   - packed entry field offsets ({tag, target, ctr}, ctr at bit 0)
//   - LRU touch/victim helpers for 1, 2 and 4 ways
package btb_pkg;

  localparam logic [1:0] CTR_SNT = 2'd0;
  localparam logic [1:0] CTR_WNT = 2'd1;
  localparam logic [1:0] CTR_WT  = 2'd2;
  localparam logic [1:0] CTR_ST  = 2'd3;

  // Entry layout, LSB first: ctr, target (PC_W bits), tag (TAG_W bits).
  localparam int unsigned CTR_OFS = 0;
  localparam int unsigned CTR_W   = 2;
  localparam int unsigned TGT_OFS = CTR_OFS + CTR_W;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == CTR_ST)  ? CTR_ST  : ctr + 2'd1;
    else       return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
  endfunction

  // 2 ways: st[0] names the LRU way.
  // 4 ways: tree PLRU; st[0] names the LRU half, st[1]/st[2] the LRU way
  // within the lower/upper half.
  function automatic logic [2:0] lru_touch(input int unsigned ways,
                                           input logic [2:0] st,
                                           input logic [1:0] way);
    logic [2:0] n;
    n = st;
    case (ways)
      2: n[0] = ~way[0];
      4: begin
        n[0] = ~way[1];
        if (way[1]) n[2] = ~way[0];
        else        n[1] = ~way[0];
      end
      default: n = st;
    endcase
    return n;
  endfunction

  function automatic logic [1:0] lru_victim(input int unsigned ways, input logic [2:0] st);
    case (ways)
      2:       return {1'b0, st[0]};
      4:       return st[0] ? {1'b1, st[2]} : {1'b0, st[1]};
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/btb_way.sv
// btb_way: one way of the BTB, 2**INDEX_W entries held in flops.
//   clk_i/rst_ni   clock, async active-low clear of valid and entry data
//   flush_i        synchronous invalidate of every entry (beats wr_en_i)
//   lk_*           lookup address in, hit/target/ctr out (combinational)
//   up_*           update address in, valid/hit/target/ctr out (combinational)
//   wr_*           write port at up_idx_i: sets valid, tag = up_tag_i
module btb_way
  import btb_pkg::*;
#(
  parameter int unsigned PC_W    = 32,
  parameter int unsigned INDEX_W = 8,
  parameter int unsigned TAG_W   = 12
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic [INDEX_W-1:0] lk_idx_i,
  input  logic [TAG_W-1:0]   lk_tag_i,
  output logic               lk_hit_o,
  output logic [PC_W-1:0]    lk_target_o,
  output logic [1:0]         lk_ctr_o,
  input  logic [INDEX_W-1:0] up_idx_i,
  input  logic [TAG_W-1:0]   up_tag_i,
  output logic               up_valid_o,
  output logic               up_hit_o,
  output logic [PC_W-1:0]    up_target_o,
  output logic [1:0]         up_ctr_o,
  input  logic               wr_en_i,
  input  logic [PC_W-1:0]    wr_target_i,
  input  logic [1:0]         wr_ctr_i
);

  localparam int unsigned SETS    = 2 ** INDEX_W;
  localparam int unsigned TAG_OFS = TGT_OFS + PC_W;
  localparam int unsigned ENT_W   = TAG_OFS + TAG_W;

  logic             valid_q [SETS];
  logic [ENT_W-1:0] ent_q   [SETS];
  logic [ENT_W-1:0] lk_ent;
  logic [ENT_W-1:0] up_ent;

  assign lk_ent      = ent_q[lk_idx_i];
  assign lk_hit_o    = valid_q[lk_idx_i] && (lk_ent[TAG_OFS +: TAG_W] == lk_tag_i);
  assign lk_target_o = lk_ent[TGT_OFS +: PC_W];
  assign lk_ctr_o    = lk_ent[CTR_OFS +: CTR_W];

  assign up_ent      = ent_q[up_idx_i];
  assign up_valid_o  = valid_q[up_idx_i];
  assign up_hit_o    = valid_q[up_idx_i] && (up_ent[TAG_OFS +: TAG_W] == up_tag_i);
  assign up_target_o = up_ent[TGT_OFS +: PC_W];
  assign up_ctr_o    = up_ent[CTR_OFS +: CTR_W];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= 1'b0;
        ent_q[s]   <= '0;
      end
    end else if (flush_i) begin
      for (int unsigned s = 0; s < SETS; s++) valid_q[s] <= 1'b0;
    end else if (wr_en_i) begin
      valid_q[up_idx_i] <= 1'b1;
      ent_q[up_idx_i]   <= {up_tag_i, wr_target_i, wr_ctr_i};
    end
  end

endmodule

// File: rtl/btb_predictor.sv
// btb_predictor: N-way set-associative BTB with 2-bit direction counters
// and LRU replacement. Prediction is registered one cycle after lookup.
//   clk, rst (async, active-low)
//   lk_en/lk_pc                          lookup request (IF stage)
//   pred_valid/pred_taken/pred_target    registered prediction (IG stage)
//   upd_en/upd_pc/upd_taken/upd_target   resolved branch (WA stage)
//   flush                                invalidate all entries
module btb_predictor
  import btb_pkg::*;
#(
  parameter int unsigned PC_W     = 32,
  parameter int unsigned INDEX_W  = 8,
  parameter int unsigned TAG_W    = 12,
  parameter int unsigned WAYS     = 2,
  parameter int unsigned CTR_INIT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lk_en,
  input  logic [PC_W-1:0] lk_pc,
  output logic            pred_valid,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            upd_en,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target,
  input  logic            flush
);

  localparam int unsigned SETS = 2 ** INDEX_W;

  logic [INDEX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0]   lk_tag, upd_tag;

  assign lk_idx  = lk_pc[2 +: INDEX_W];
  assign lk_tag  = lk_pc[2+INDEX_W +: TAG_W];
  assign upd_idx = upd_pc[2 +: INDEX_W];
  assign upd_tag = upd_pc[2+INDEX_W +: TAG_W];

  logic            w_lk_hit   [WAYS];
  logic [PC_W-1:0] w_lk_tgt   [WAYS];
  logic [1:0]      w_lk_ctr   [WAYS];
  logic            w_up_valid [WAYS];
  logic            w_up_hit   [WAYS];
  logic [PC_W-1:0] w_up_tgt   [WAYS];
  logic [1:0]      w_up_ctr   [WAYS];
  logic            w_wr_en    [WAYS];

  logic [PC_W-1:0] wr_tgt;
  logic [1:0]      wr_ctr;

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    btb_way #(
      .PC_W   (PC_W),
      .INDEX_W(INDEX_W),
      .TAG_W  (TAG_W)
    ) u_way (
      .clk_i      (clk),
      .rst_ni     (rst),
      .flush_i    (flush),
      .lk_idx_i   (lk_idx),
      .lk_tag_i   (lk_tag),
      .lk_hit_o   (w_lk_hit[g]),
      .lk_target_o(w_lk_tgt[g]),
      .lk_ctr_o   (w_lk_ctr[g]),
      .up_idx_i   (upd_idx),
      .up_tag_i   (upd_tag),
      .up_valid_o (w_up_valid[g]),
      .up_hit_o   (w_up_hit[g]),
      .up_target_o(w_up_tgt[g]),
      .up_ctr_o   (w_up_ctr[g]),
      .wr_en_i    (w_wr_en[g]),
      .wr_target_i(wr_tgt),
      .wr_ctr_i   (wr_ctr)
    );
  end

  logic [2:0]      lru_q [SETS];
  logic            pred_valid_q, pred_taken_q;
  logic [PC_W-1:0] pred_target_q;

  // Lookup select: lowest hitting way wins.
  logic            lk_any;
  logic [1:0]      lk_way;
  logic [PC_W-1:0] lk_tgt;
  logic [1:0]      lk_ctr;
  logic            lk_touch;

  always_comb begin
    lk_any = 1'b0;
    lk_way = '0;
    lk_tgt = '0;
    lk_ctr = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (w_lk_hit[w] && !lk_any) begin
        lk_any = 1'b1;
        lk_way = 2'(w);
        lk_tgt = w_lk_tgt[w];
        lk_ctr = w_lk_ctr[w];
      end
    end
    lk_touch = lk_en && lk_any;
  end

  // Update: hit way, else first invalid way, else LRU victim.
  logic            up_any, inv_any, wr_do;
  logic [1:0]      up_way, inv_way, wr_way;
  logic [PC_W-1:0] up_tgt;
  logic [1:0]      up_ctr;

  always_comb begin
    up_any  = 1'b0;
    up_way  = '0;
    up_tgt  = '0;
    up_ctr  = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (w_up_hit[w] && !up_any) begin
        up_any = 1'b1;
        up_way = 2'(w);
        up_tgt = w_up_tgt[w];
        up_ctr = w_up_ctr[w];
      end
      if (!w_up_valid[w] && !inv_any) begin
        inv_any = 1'b1;
        inv_way = 2'(w);
      end
    end
    wr_way = up_any ? up_way : (inv_any ? inv_way : lru_victim(WAYS, lru_q[upd_idx]));
    wr_do  = upd_en && !flush && (up_any || upd_taken);
    wr_ctr = up_any ? ctr_next(up_ctr, upd_taken) : 2'(CTR_INIT);
    wr_tgt = (up_any && !upd_taken) ? up_tgt : upd_target;
    for (int unsigned w = 0; w < WAYS; w++) w_wr_en[w] = wr_do && (wr_way == 2'(w));
  end

  // The update's touch is layered on top of the lookup's so that, in a
  // shared set, the updated way ends up MRU.
  logic [2:0] lk_lru_new, up_lru_base, up_lru_new;

  always_comb begin
    lk_lru_new  = lru_touch(WAYS, lru_q[lk_idx], lk_way);
    up_lru_base = (lk_touch && (lk_idx == upd_idx)) ? lk_lru_new : lru_q[upd_idx];
    up_lru_new  = lru_touch(WAYS, up_lru_base, wr_way);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned s = 0; s < SETS; s++) lru_q[s] <= '0;
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
    end else begin
      if (lk_touch) lru_q[lk_idx]  <= lk_lru_new;
      if (wr_do)    lru_q[upd_idx] <= up_lru_new;
      pred_valid_q  <= lk_touch;
      pred_taken_q  <= lk_touch && lk_ctr[1];
      pred_target_q <= lk_touch ? lk_tgt : '0;
    end
  end

  assign pred_valid  = pred_valid_q;
  assign pred_taken  = pred_taken_q;
  assign pred_target = pred_target_q;

endmodule

// File: tb/tb_btb_predictor.sv
// tb_btb_predictor: table-driven self-checking bench for btb_predictor
// (INDEX_W = 4, WAYS = 2). Each vector drives one cycle; its expected
// prediction is queued and compared on the following falling edge.
module tb_btb_predictor;

  logic        clk, rst;
  logic        lk_en, upd_en, upd_taken, flush;
  logic [31:0] lk_pc, upd_pc, upd_target;
  logic        pred_valid, pred_taken;
  logic [31:0] pred_target;

  btb_predictor #(
    .PC_W    (32),
    .INDEX_W (4),
    .TAG_W   (12),
    .WAYS    (2),
    .CTR_INIT(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .lk_en      (lk_en),
    .lk_pc      (lk_pc),
    .pred_valid (pred_valid),
    .pred_taken (pred_taken),
    .pred_target(pred_target),
    .upd_en     (upd_en),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_target (upd_target),
    .flush      (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        lk_en;
    logic [31:0] lk_pc;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        flush;
    logic        ev;
    logic        et;
    logic [31:0] etgt;
    string       name;
  } vec_t;

  typedef struct {
    logic        ev;
    logic        et;
    logic [31:0] etgt;
    string       name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic le, logic [31:0] lp, logic ue, logic [31:0] up,
                              logic ut, logic [31:0] utg, logic fl,
                              logic ev, logic et, logic [31:0] etg, string nm);
    vec_t r;
    r.lk_en = le; r.lk_pc = lp; r.upd_en = ue; r.upd_pc = up;
    r.upd_taken = ut; r.upd_target = utg; r.flush = fl;
    r.ev = ev; r.et = et; r.etgt = etg; r.name = nm;
    return r;
  endfunction

  function automatic vec_t L(logic [31:0] pc, logic ev, logic et, logic [31:0] etg, string nm);
    return mk(1'b1, pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, ev, et, etg, nm);
  endfunction

  function automatic vec_t U(logic [31:0] pc, logic tk, logic [31:0] tg, string nm);
    return mk(1'b0, 32'h0, 1'b1, pc, tk, tg, 1'b0, 1'b0, 1'b0, 32'h0, nm);
  endfunction

  task automatic cmp(input string nm, input logic ev, input logic et, input logic [31:0] etg);
    checks++;
    if (pred_valid !== ev || pred_taken !== et || pred_target !== etg) begin
      errors++;
      $display("FAIL %s: got valid=%b taken=%b target=%h, expected valid=%b taken=%b target=%h",
               nm, pred_valid, pred_taken, pred_target, ev, et, etg);
    end
  endtask

  task automatic step(input vec_t v);
    exp_t e;
    lk_en = v.lk_en; lk_pc = v.lk_pc;
    upd_en = v.upd_en; upd_pc = v.upd_pc;
    upd_taken = v.upd_taken; upd_target = v.upd_target;
    flush = v.flush;
    e.ev = v.ev; e.et = v.et; e.etgt = v.etgt; e.name = v.name;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: got empty queue, expected entry for %s", v.name);
    end else begin
      e = sb.pop_front();
      cmp(e.name, e.ev, e.et, e.etgt);
    end
  endtask

  task automatic run_vecs();
    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);
    vecs.delete();
  endtask

  task automatic idle_inputs();
    lk_en = 1'b0; lk_pc = '0; upd_en = 1'b0; upd_pc = '0;
    upd_taken = 1'b0; upd_target = '0; flush = 1'b0;
  endtask

  task automatic reset_pulse();
    idle_inputs();
    rst = 1'b0;
    #1 cmp("reset_pulse", 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    #1 cmp("reset_state", 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Allocation and counter saturation on a single entry.
    vecs.push_back(L(32'h40, 0, 0, 32'h0,   "miss_after_reset"));
    vecs.push_back(U(32'h40, 1, 32'h100,     "lk_en_low"));
    vecs.push_back(L(32'h40, 1, 1, 32'h100, "alloc_weak_taken"));
    vecs.push_back(U(32'h40, 0, 32'hDEAD0000, "idle"));
    vecs.push_back(L(32'h40, 1, 0, 32'h100, "ctr_weak_nt_keeps_tgt"));
    vecs.push_back(U(32'h40, 0, 32'hDEAD0000, "idle"));
    vecs.push_back(U(32'h40, 0, 32'hDEAD0000, "idle"));
    vecs.push_back(L(32'h40, 1, 0, 32'h100, "sat_low"));
    vecs.push_back(U(32'h40, 1, 32'h100,     "idle"));
    vecs.push_back(U(32'h40, 1, 32'h100,     "idle"));
    vecs.push_back(U(32'h40, 1, 32'h100,     "idle"));
    vecs.push_back(U(32'h40, 1, 32'h100,     "idle"));
    vecs.push_back(U(32'h40, 0, 32'hDEAD0000, "idle"));
    vecs.push_back(L(32'h40, 1, 1, 32'h100, "sat_high"));
    vecs.push_back(U(32'h48, 0, 32'h800,     "idle"));
    vecs.push_back(L(32'h48, 0, 0, 32'h0,   "nt_miss_no_alloc"));
    run_vecs();

    // Aliasing in set 0 and LRU replacement.
    reset_pulse();
    vecs.push_back(U(32'h40, 1, 32'h200,     "idle"));
    vecs.push_back(U(32'h80, 1, 32'h300,     "idle"));
    vecs.push_back(L(32'h40, 1, 1, 32'h200, "alias_hit_40"));
    vecs.push_back(U(32'hC0, 1, 32'h400,     "idle"));
    vecs.push_back(L(32'h80, 0, 0, 32'h0,   "evict_80"));
    vecs.push_back(L(32'h43, 1, 1, 32'h200, "hit_40_lowbits"));
    vecs.push_back(L(32'hC0, 1, 1, 32'h400, "hit_C0"));
    vecs.push_back(L(32'h44, 0, 0, 32'h0,   "other_index_miss"));
    vecs.push_back(mk(1, 32'h40, 1, 32'hC0, 1, 32'h500, 0, 1, 1, 32'h200, "lk_upd_same_set"));
    vecs.push_back(U(32'h100, 1, 32'h600,    "idle"));
    vecs.push_back(L(32'h40, 0, 0, 32'h0,   "upd_touch_priority"));
    vecs.push_back(L(32'hC0, 1, 1, 32'h500, "hit_C0_new_tgt"));
    vecs.push_back(L(32'h100, 1, 1, 32'h600, "hit_100"));
    run_vecs();

    // Read-before-write, target overwrite, flush.
    reset_pulse();
    vecs.push_back(mk(1, 32'h40, 1, 32'h40, 1, 32'h100, 0, 0, 0, 32'h0, "rbw_miss"));
    vecs.push_back(L(32'h40, 1, 1, 32'h100, "rbw_hit_next"));
    vecs.push_back(mk(1, 32'h40, 1, 32'h40, 1, 32'h180, 0, 1, 1, 32'h100, "rbw_old_tgt"));
    vecs.push_back(L(32'h40, 1, 1, 32'h180, "tgt_overwrite"));
    vecs.push_back(U(32'h44, 1, 32'h700,     "idle"));
    vecs.push_back(mk(1, 32'h40, 1, 32'h80, 1, 32'h900, 1, 1, 1, 32'h180, "flush_pre_data"));
    vecs.push_back(L(32'h40, 0, 0, 32'h0,   "flush_miss_40"));
    vecs.push_back(L(32'h44, 0, 0, 32'h0,   "flush_miss_44"));
    vecs.push_back(L(32'h80, 0, 0, 32'h0,   "flush_over_upd"));
    vecs.push_back(U(32'h40, 1, 32'h100,     "idle"));
    vecs.push_back(L(32'h40, 1, 1, 32'h100, "pre_async"));
    run_vecs();

    // Asynchronous reset mid-cycle, lookup of 0x40 still requested.
    lk_en = 1'b1; lk_pc = 32'h40;
    #2 rst = 1'b0;
    #1 cmp("async_reset", 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    step(L(32'h40, 0, 0, 32'h0, "first_after_release"));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish within 100000 time units");
    $fatal(1);
  end

endmodule
